// File: rtl/rc4_task_sequencer.sv
// RC4 task sequencer: runs init -> shuffle -> decrypt in order, muxes the active
// task onto the shared S-memory port and watches each task with a watchdog.
module rc4_task_sequencer #(
  parameter int unsigned TIMEOUT = 2048
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       abort,
  output logic       init_start,
  output logic       shuffle_start,
  output logic       decrypt_start,
  input  logic       init_done,
  input  logic       shuffle_done,
  input  logic       decrypt_done,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_data,
  input  logic [7:0] shuffle_addr,
  input  logic [7:0] shuffle_data,
  input  logic [7:0] decrypt_addr,
  input  logic [7:0] decrypt_data,
  input  logic       init_wren,
  input  logic       shuffle_wren,
  input  logic       decrypt_wren,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_wren,
  output logic       busy,
  output logic       all_done,
  output logic       error,
  output logic [1:0] err_stage
);

  // Task states are encoded so their low two bits equal the err_stage code.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INIT    = 3'd1;
  localparam logic [2:0] ST_SHUFFLE = 3'd2;
  localparam logic [2:0] ST_DECRYPT = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_ERROR   = 3'd5;

  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] wdog_q, wdog_d;
  logic [1:0]  err_stage_q, err_stage_d;
  logic        init_start_q, init_start_d;
  logic        shuffle_start_q, shuffle_start_d;
  logic        decrypt_start_q, decrypt_start_d;
  logic        active_done;

  // Completion flag of the task owning the current state; others are ignored.
  always_comb begin
    active_done = 1'b0;
    case (state_q)
      ST_INIT:    active_done = init_done;
      ST_SHUFFLE: active_done = shuffle_done;
      ST_DECRYPT: active_done = decrypt_done;
      default:    active_done = 1'b0;
    endcase
  end

  // Next state: abort beats everything, then done beats the watchdog.
  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    err_stage_d = err_stage_q;
    if (abort) begin
      state_d     = ST_IDLE;
      wdog_d      = 16'd0;
      err_stage_d = 2'b00;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (go) begin
            state_d     = ST_INIT;
            wdog_d      = 16'd0;
            err_stage_d = 2'b00;
          end
        end
        ST_INIT, ST_SHUFFLE, ST_DECRYPT: begin
          if (active_done) begin
            wdog_d = 16'd0;
            case (state_q)
              ST_INIT:    state_d = ST_SHUFFLE;
              ST_SHUFFLE: state_d = ST_DECRYPT;
              default:    state_d = ST_DONE;
            endcase
          end else if (wdog_q == WDOG_LIMIT) begin
            state_d     = ST_ERROR;
            wdog_d      = 16'd0;
            err_stage_d = state_q[1:0];
          end else begin
            wdog_d = wdog_q + 16'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          wdog_d  = 16'd0;
        end
      endcase
    end
  end

  // Start enables are registered copies of the next state so they track state exactly.
  always_comb begin
    init_start_d    = (state_d == ST_INIT);
    shuffle_start_d = (state_d == ST_SHUFFLE);
    decrypt_start_d = (state_d == ST_DECRYPT);
  end

  // State, watchdog, error stage and start registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      wdog_q          <= 16'd0;
      err_stage_q     <= 2'b00;
      init_start_q    <= 1'b0;
      shuffle_start_q <= 1'b0;
      decrypt_start_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wdog_q          <= wdog_d;
      err_stage_q     <= err_stage_d;
      init_start_q    <= init_start_d;
      shuffle_start_q <= shuffle_start_d;
      decrypt_start_q <= decrypt_start_d;
    end
  end

  // Zero-latency memory mux driven by the registered state.
  always_comb begin
    mem_addr = 8'd0;
    mem_data = 8'd0;
    mem_wren = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_addr = init_addr;
        mem_data = init_data;
        mem_wren = init_wren;
      end
      ST_SHUFFLE: begin
        mem_addr = shuffle_addr;
        mem_data = shuffle_data;
        mem_wren = shuffle_wren;
      end
      ST_DECRYPT: begin
        mem_addr = decrypt_addr;
        mem_data = decrypt_data;
        mem_wren = decrypt_wren;
      end
      default: ;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy          = (state_q == ST_INIT) || (state_q == ST_SHUFFLE) || (state_q == ST_DECRYPT);
    all_done      = (state_q == ST_DONE);
    error         = (state_q == ST_ERROR);
    err_stage     = err_stage_q;
    init_start    = init_start_q;
    shuffle_start = shuffle_start_q;
    decrypt_start = decrypt_start_q;
  end

endmodule

// File: tb/tb_rc4_task_sequencer.sv
// Bench for rc4_task_sequencer: a long-timeout and a short-timeout instance share
// stimulus and are both checked every cycle against a stage/age reference model.
module tb_rc4_task_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       go, abort;
  logic       init_done, shuffle_done, decrypt_done;
  logic [7:0] init_addr, init_data, shuffle_addr, shuffle_data, decrypt_addr, decrypt_data;
  logic       init_wren, shuffle_wren, decrypt_wren;

  logic       l_is, l_ss, l_ds, l_wren, l_busy, l_all, l_err;
  logic [7:0] l_addr, l_data;
  logic [1:0] l_es;
  logic       s_is, s_ss, s_ds, s_wren, s_busy, s_all, s_err;
  logic [7:0] s_addr, s_data;
  logic [1:0] s_es;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model, per instance: 0 idle, 1 init, 2 shuffle, 3 decrypt, 4 done, 5 error.
  int m_stage[2];
  int m_age[2];
  int m_err[2];
  int tmo[2] = '{2048, 16};

  always #5 clk = ~clk;

  rc4_task_sequencer dut_l (
    .clk(clk), .reset(reset), .go(go), .abort(abort),
    .init_start(l_is), .shuffle_start(l_ss), .decrypt_start(l_ds),
    .init_done(init_done), .shuffle_done(shuffle_done), .decrypt_done(decrypt_done),
    .init_addr(init_addr), .init_data(init_data),
    .shuffle_addr(shuffle_addr), .shuffle_data(shuffle_data),
    .decrypt_addr(decrypt_addr), .decrypt_data(decrypt_data),
    .init_wren(init_wren), .shuffle_wren(shuffle_wren), .decrypt_wren(decrypt_wren),
    .mem_addr(l_addr), .mem_data(l_data), .mem_wren(l_wren),
    .busy(l_busy), .all_done(l_all), .error(l_err), .err_stage(l_es)
  );

  rc4_task_sequencer #(.TIMEOUT(16)) dut_s (
    .clk(clk), .reset(reset), .go(go), .abort(abort),
    .init_start(s_is), .shuffle_start(s_ss), .decrypt_start(s_ds),
    .init_done(init_done), .shuffle_done(shuffle_done), .decrypt_done(decrypt_done),
    .init_addr(init_addr), .init_data(init_data),
    .shuffle_addr(shuffle_addr), .shuffle_data(shuffle_data),
    .decrypt_addr(decrypt_addr), .decrypt_data(decrypt_data),
    .init_wren(init_wren), .shuffle_wren(shuffle_wren), .decrypt_wren(decrypt_wren),
    .mem_addr(s_addr), .mem_data(s_data), .mem_wren(s_wren),
    .busy(s_busy), .all_done(s_all), .error(s_err), .err_stage(s_es)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_stage[i] = 0;
      m_age[i]   = 0;
      m_err[i]   = 0;
    end
  endtask

  // One clock of the rules: abort wins; a task ends on its own done, otherwise
  // fails when this is its tmo-th cycle in the stage.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int  st;
      logic d;
      st = m_stage[i];
      d  = (st == 1) ? init_done : (st == 2) ? shuffle_done : (st == 3) ? decrypt_done : 1'b0;
      if (abort) begin
        m_stage[i] = 0; m_age[i] = 0; m_err[i] = 0;
      end else if (st == 0 || st >= 4) begin
        if (go) begin
          m_stage[i] = 1; m_age[i] = 0; m_err[i] = 0;
        end
      end else if (d) begin
        m_stage[i] = st + 1; m_age[i] = 0;
      end else if (m_age[i] + 1 == tmo[i]) begin
        m_stage[i] = 5; m_age[i] = 0; m_err[i] = st;
      end else begin
        m_age[i] = m_age[i] + 1;
      end
    end
  endtask

  function automatic logic [31:0] exp_ctl(input int i);
    int st;
    st = m_stage[i];
    return {24'd0, st == 1, st == 2, st == 3, st >= 1 && st <= 3, st == 4, st == 5, 2'(m_err[i])};
  endfunction

  function automatic logic [31:0] exp_mux(input int i);
    case (m_stage[i])
      1:       return {15'd0, init_addr, init_data, init_wren};
      2:       return {15'd0, shuffle_addr, shuffle_data, shuffle_wren};
      3:       return {15'd0, decrypt_addr, decrypt_data, decrypt_wren};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_all();
    check("ctl_long",  {24'd0, l_is, l_ss, l_ds, l_busy, l_all, l_err, l_es}, exp_ctl(0));
    check("mux_long",  {15'd0, l_addr, l_data, l_wren}, exp_mux(0));
    check("ctl_short", {24'd0, s_is, s_ss, s_ds, s_busy, s_all, s_err, s_es}, exp_ctl(1));
    check("mux_short", {15'd0, s_addr, s_data, s_wren}, exp_mux(1));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse_go();
    go = 1'b1; step(); go = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    {go, abort, init_done, shuffle_done, decrypt_done} = '0;
    {init_addr, init_data, shuffle_addr, shuffle_data, decrypt_addr, decrypt_data} = '0;
    {init_wren, shuffle_wren, decrypt_wren} = '0;
    model_reset();
    #12;
    check_all();
    reset = 1'b0;

    // Idle without go: nothing moves.
    steps(4);

    // Nominal run on the long instance.
    pulse_go();
    steps(256);
    init_done = 1'b1; step(); init_done = 1'b0;
    // Shared port shows only the shuffle task.
    shuffle_addr = 8'h3C; shuffle_data = 8'hA5; shuffle_wren = 1'b1; init_wren = 1'b1;
    step();
    check("mux_3c", {15'd0, l_addr, l_data, l_wren}, {15'd0, 8'h3C, 8'hA5, 1'b1});
    shuffle_wren = 1'b0; init_wren = 1'b0;
    steps(768);
    shuffle_done = 1'b1; step(); shuffle_done = 1'b0;
    steps(99);
    decrypt_done = 1'b1; step(); decrypt_done = 1'b0;
    check("nominal_all_done", {31'd0, l_all}, 32'd1);
    steps(3);

    // Abort together with decrypt_done; stray shuffle_done in INIT.
    pulse_go();
    init_done = 1'b1; step(); init_done = 1'b0;
    shuffle_done = 1'b1; step(); shuffle_done = 1'b0;
    abort = 1'b1; decrypt_done = 1'b1; step(); abort = 1'b0; decrypt_done = 1'b0;
    check("abort_prio", {30'd0, l_busy, l_all}, 32'd0);
    pulse_go();
    shuffle_done = 1'b1; step(); shuffle_done = 1'b0;
    check("stray_done", {30'd0, l_is, l_ss}, 32'd2);

    // Race: done on the 16th INIT cycle beats the watchdog.
    do_abort();
    pulse_go();
    steps(15);
    init_done = 1'b1; step(); init_done = 1'b0;
    check("race_short", {30'd0, s_ss, s_err}, 32'd2);

    // Timeout in SHUFFLE on the short instance.
    do_abort();
    pulse_go();
    init_done = 1'b1; step(); init_done = 1'b0;
    n = 0;
    while (!s_err && n < 40) begin
      step();
      n++;
    end
    check("timeout_cycles", n, 16);
    check("timeout_stage", {29'd0, s_es, s_ss}, {29'd0, 2'b10, 1'b0});
    pulse_go();
    check("restart_clear", {29'd0, s_es, s_is}, {29'd0, 2'b00, 1'b1});

    // Reset asserted mid-SHUFFLE on the long instance.
    do_abort();
    pulse_go();
    init_done = 1'b1; step(); init_done = 1'b0;
    shuffle_wren = 1'b1;
    step();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_all();
    check("reset_async", {30'd0, l_ss, l_wren}, 32'd0);
    #3 reset = 1'b0;
    shuffle_wren = 1'b0;
    steps(2);
    pulse_go();

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      go           = ($urandom_range(0, 7) == 0);
      abort        = ($urandom_range(0, 39) == 0);
      init_done    = ($urandom_range(0, 7) == 0);
      shuffle_done = ($urandom_range(0, 7) == 0);
      decrypt_done = ($urandom_range(0, 7) == 0);
      init_addr    = 8'($urandom); init_data    = 8'($urandom);
      shuffle_addr = 8'($urandom); shuffle_data = 8'($urandom);
      decrypt_addr = 8'($urandom); decrypt_data = 8'($urandom);
      init_wren    = 1'($urandom); shuffle_wren = 1'($urandom); decrypt_wren = 1'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rc4_task_sequencer.md
RC4_TASK_SEQUENCER -- requirements
Module: rc4_task_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 2048, per-task watchdog limit in cycles (legal range 2..65535).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 go  in  1  request to run the full init->shuffle->decrypt sequence; sampled in IDLE, DONE, ERROR.
REQ-005 abort  in  1  return to IDLE from any state.
REQ-006 init_start / shuffle_start / decrypt_start  out  1 each  level-held enable to the corresponding task; a low level holds the task in its cleared state.
REQ-007 init_done / shuffle_done / decrypt_done  in  1 each  task completion flag.
REQ-008 init_addr, init_data, shuffle_addr, shuffle_data, decrypt_addr, decrypt_data  in  8 each  task memory requests.
REQ-009 init_wren, shuffle_wren, decrypt_wren  in  1 each  task write enables.
REQ-010 mem_addr  out  8, mem_data  out  8, mem_wren  out  1  shared 256x8 S-memory port.
REQ-011 busy  out  1  high in INIT, SHUFFLE, DECRYPT.
REQ-012 all_done  out  1  high in DONE.
REQ-013 error  out  1  high in ERROR; err_stage  out  2  failing stage (01 init, 10 shuffle, 11 decrypt, 00 none).

Function
REQ-014 States: IDLE, INIT, SHUFFLE, DECRYPT, DONE, ERROR; state register and all *_start outputs registered.
REQ-015 IDLE/DONE/ERROR with go=1 -> INIT next cycle; init_start=1 from that cycle.
REQ-016 INIT with init_done=1 -> SHUFFLE next cycle; same edge: init_start 1->0, shuffle_start 0->1.
REQ-017 SHUFFLE with shuffle_done=1 -> DECRYPT; shuffle_start->0, decrypt_start->1 on the same edge.
REQ-018 DECRYPT with decrypt_done=1 -> DONE; decrypt_start->0.
REQ-019 At most one *_start high in any cycle; *_start equals 1 exactly while in its matching state.
REQ-020 done inputs of non-active tasks ignored (e.g. shuffle_done in INIT has no effect).
REQ-021 Memory mux combinational from registered state: INIT selects init_*, SHUFFLE shuffle_*, DECRYPT decrypt_*; zero-cycle latency.
REQ-022 In IDLE, DONE, ERROR: mem_addr=0, mem_data=0, mem_wren=0.
REQ-023 Watchdog: 16-bit counter cleared on every state entry, +1 each cycle in INIT/SHUFFLE/DECRYPT while active done=0.
REQ-024 Counter reaching TIMEOUT-1 with active done=0 -> ERROR next cycle; err_stage set to active stage; all *_start->0.
REQ-025 Active done=1 in the same cycle as the timeout condition: done wins, normal transition.
REQ-026 abort=1 -> IDLE next cycle from any state, all *_start->0, err_stage->00; abort has priority over go, done and timeout.
REQ-027 err_stage holds until next go (cleared to 00 on entry to INIT), abort or reset.
REQ-028 all_done stays high in DONE until go or abort; go in DONE restarts at INIT with all_done->0 on the same edge.
REQ-029 go while busy ignored.

Reset
REQ-030 reset=1 asynchronously forces state=IDLE, all *_start=0, watchdog=0, err_stage=00, busy=0, all_done=0, error=0; mem_* = 0 via REQ-022.
REQ-031 Reset mid-task drops *_start immediately (asynchronously), which clears the task; no memory write issued after the reset assertion cycle.
REQ-032 After reset release, no transition until go=1 is sampled.

Verification
REQ-033 Nominal: go pulse; init_done after 257 cycles, shuffle_done after 770, decrypt_done after 100 -> states in order, busy=1 throughout, all_done=1 the cycle after decrypt_done, exactly one *_start high at a time.
REQ-034 Mux: in SHUFFLE drive shuffle_addr=0x3C, data=0xA5, wren=1 and init_wren=1 -> mem_addr=0x3C, mem_data=0xA5, mem_wren=1 same cycle; init_wren invisible.
REQ-035 Timeout: TIMEOUT=16, shuffle_done never asserted -> ERROR 16 cycles after entering SHUFFLE, err_stage=10, shuffle_start=0; go -> INIT, err_stage=00.
REQ-036 Race: TIMEOUT=16, init_done asserted on the 16th INIT cycle -> SHUFFLE, error=0.
REQ-037 Abort/priority: abort and decrypt_done together in DECRYPT -> IDLE, all_done=0; stray shuffle_done in INIT -> no transition.
REQ-038 Reset mid-SHUFFLE -> shuffle_start=0 and mem_wren=0 before next clk edge; go after release -> INIT.
